difficulty_select: RTL

//  Menu-side driver of the level-select interface: turns raw player keys into the held

---
 rtl/difficulty_pkg.sv | 41 ++++
 rtl/key_conditioner.sv | 47 ++++
 rtl/difficulty_select.sv | 112 +++++++++++
 3 files changed

// File: rtl/difficulty_pkg.sv
// Shared level/state definitions for the level-select interface, also used by the
// difficulty decoder and the menu display.
package difficulty_pkg;

  localparam int LVL_W = 2;

  localparam logic [LVL_W-1:0] LVL_EASY = 2'd0;
  localparam logic [LVL_W-1:0] LVL_MED  = 2'd1;
  localparam logic [LVL_W-1:0] LVL_HARD = 2'd2;

  typedef enum logic {
    ST_MENU = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // {hard, med, easy} line pattern for a level; anything unexpected maps to EASY
  function automatic logic [2:0] level_lines(input logic [LVL_W-1:0] lvl);
    case (lvl)
      LVL_HARD: return 3'b100;
      LVL_MED:  return 3'b010;
      default:  return 3'b001;
    endcase
  endfunction

  function automatic logic [LVL_W-1:0] lvl_next(input logic [LVL_W-1:0] lvl);
    case (lvl)
      LVL_EASY: return LVL_MED;
      LVL_MED:  return LVL_HARD;
      default:  return LVL_EASY;
    endcase
  endfunction

  function automatic logic [LVL_W-1:0] lvl_prev(input logic [LVL_W-1:0] lvl);
    case (lvl)
      LVL_HARD: return LVL_MED;
      LVL_MED:  return LVL_EASY;
      default:  return LVL_HARD;
    endcase
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw key conditioning: two-flop synchroniser, stability debounce and a one-cycle
// pulse on each debounced press.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic pulse
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            db;
  logic [DB_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the synchroniser chain it describes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      // Debounced value starts as "pressed": a key held through reset must be
      // released before it can count as a new press; an idle key settles silently.
      db    <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        db    <= sync2;
        pulse <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/difficulty_select.sv
// Menu-side level-select driver: debounced keys move a cursor and commit one held
// hard/med/easy line. Optional idle auto-commit when MENU_TIMEOUT_EN is defined.
module difficulty_select
  import difficulty_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int TO_W            = 29
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_select,
  input  logic             key_back,
  input  logic             game_done,
  output logic             hard,
  output logic             med,
  output logic             easy,
  output logic [LVL_W-1:0] highlight,
  output logic             menu_active
);

  logic up_p, down_p, sel_p, back_p;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_up (
    .clock(clock), .resetn(resetn), .raw(key_up), .pulse(up_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_down (
    .clock(clock), .resetn(resetn), .raw(key_down), .pulse(down_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_select (
    .clock(clock), .resetn(resetn), .raw(key_select), .pulse(sel_p));
  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_back (
    .clock(clock), .resetn(resetn), .raw(key_back), .pulse(back_p));

  state_t           state, state_nx;
  logic [LVL_W-1:0] hl_cur, hl_nx;
  logic [2:0]       lines_nx;
  logic             any_pulse;
  logic             timeout_hit;

  assign any_pulse = up_p | down_p | sel_p | back_p;

`ifdef MENU_TIMEOUT_EN
  logic [TO_W-1:0] idle_cnt;

  // Any key activity restarts the idle window, so it never commits alongside a key.
  assign timeout_hit = (state == ST_MENU) && !any_pulse &&
                       (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      idle_cnt <= '0;
    end else if (state != ST_MENU || any_pulse || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A cursor value of 3 should never occur; it is read as EASY and rewritten.
  assign hl_cur = (highlight == 2'd3) ? LVL_EASY : highlight;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    hl_nx    = hl_cur;
    lines_nx = {hard, med, easy};
    case (state)
      ST_MENU: begin
        lines_nx = 3'b000;
        if (sel_p || timeout_hit) begin
          state_nx = ST_PLAY;
          lines_nx = level_lines(hl_cur);
        end else if (down_p && !up_p) begin
          hl_nx = lvl_next(hl_cur);
        end else if (up_p && !down_p) begin
          hl_nx = lvl_prev(hl_cur);
        end
      end
      ST_PLAY: begin
        if (back_p || game_done) begin
          state_nx = ST_MENU;
          lines_nx = 3'b000;
        end
      end
      default: begin
        state_nx = ST_MENU;
        lines_nx = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state              <= ST_MENU;
      highlight          <= LVL_EASY;
      {hard, med, easy}  <= 3'b000;
      menu_active        <= 1'b1;
    end else begin
      state              <= state_nx;
      highlight          <= hl_nx;
      {hard, med, easy}  <= lines_nx;
      menu_active        <= (state_nx == ST_MENU);
    end
  end

endmodule
